// File: rtl/ksa_fsm.sv
// rtl/ksa_fsm.sv - RC4 state-array init and key-scheduling FSM on the shared S RAM
// Builds S[i]=i, then runs the RC4 key schedule with secret_key, swapping in place.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   start           level request, sampled in IDLE; held by the consumer until done
//   stop            abort from the core arbiter (ignored in IDLE and DONE)
//   secret_key      key bytes, byte 0 in the most significant position
//   q               RAM read data, valid MEM_LAT cycles after an address update
//   address, data   RAM address and write data (registered)
//   wren, rden      RAM write and read enables (registered)
//   busy, done      busy outside IDLE/DONE; done high only in DONE
module ksa_fsm #(
    parameter int KEY_BYTES = 3,
    parameter int MEM_LAT   = 2  // must be >= 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [7:0]             q,
    output logic [7:0]             address,
    output logic [7:0]             data,
    output logic                   wren,
    output logic                   rden,
    output logic                   busy,
    output logic                   done
);
    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam int WW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [KW-1:0] KEY_LAST  = KW'(KEY_BYTES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_LAT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_INIT_END, S_RD_I, S_W_I, S_CALC_J,
        S_RD_J, S_W_J, S_WR_J, S_WR_I, S_NEXT, S_DONE
    } state_t;

    state_t        state_q;
    logic [7:0]    i_q, j_q, tmp_i_q, tmp_j_q;
    logic [KW-1:0] kidx_q;   // i mod KEY_BYTES, advanced alongside i
    logic [WW-1:0] wait_q;   // RAM read-latency wait counter
    logic [7:0]    address_q, data_q;
    logic          wren_q, rden_q, busy_q, done_q;
    logic [7:0]    key_byte;

    always_comb begin
        key_byte = 8'h00;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (kidx_q == KW'(k)) begin
                key_byte = secret_key[8*(KEY_BYTES-1-k) +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            i_q       <= 8'h00;
            j_q       <= 8'h00;
            tmp_i_q   <= 8'h00;
            tmp_j_q   <= 8'h00;
            kidx_q    <= '0;
            wait_q    <= '0;
            address_q <= 8'h00;
            data_q    <= 8'h00;
            wren_q    <= 1'b0;
            rden_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (stop && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            // Abort replaces the state's own action, so no write leaves this cycle.
            state_q <= S_IDLE;
            wren_q  <= 1'b0;
            rden_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_INIT;
                        i_q     <= 8'h00;
                        busy_q  <= 1'b1;
                    end
                end
                S_INIT: begin
                    address_q <= i_q;
                    data_q    <= i_q;
                    wren_q    <= 1'b1;
                    i_q       <= i_q + 8'd1;
                    if (i_q == 8'hFF) begin
                        state_q <= S_INIT_END;
                    end
                end
                S_INIT_END: begin
                    wren_q  <= 1'b0;
                    rden_q  <= 1'b1;
                    i_q     <= 8'h00;
                    j_q     <= 8'h00;
                    kidx_q  <= '0;
                    state_q <= S_RD_I;
                end
                S_RD_I: begin
                    address_q <= i_q;
                    wait_q    <= '0;
                    state_q   <= S_W_I;
                end
                S_W_I: begin
                    if (wait_q == WAIT_LAST) state_q <= S_CALC_J;
                    else                     wait_q  <= wait_q + WW'(1);
                end
                S_CALC_J: begin
                    tmp_i_q <= q;
                    j_q     <= j_q + q + key_byte;
                    state_q <= S_RD_J;
                end
                S_RD_J: begin
                    address_q <= j_q;
                    wait_q    <= '0;
                    state_q   <= S_W_J;
                end
                S_W_J: begin
                    if (wait_q == WAIT_LAST) state_q <= S_WR_J;
                    else                     wait_q  <= wait_q + WW'(1);
                end
                S_WR_J: begin
                    // s[j] is captured before either write, so i==j needs no special case.
                    tmp_j_q <= q;
                    wren_q  <= 1'b1;
                    rden_q  <= 1'b0;
                    data_q  <= tmp_i_q;
                    state_q <= S_WR_I;
                end
                S_WR_I: begin
                    address_q <= i_q;
                    data_q    <= tmp_j_q;
                    state_q   <= S_NEXT;
                end
                S_NEXT: begin
                    wren_q <= 1'b0;
                    rden_q <= 1'b1;
                    if (i_q == 8'hFF) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                    end else begin
                        i_q     <= i_q + 8'd1;
                        kidx_q  <= (kidx_q == KEY_LAST) ? '0 : kidx_q + KW'(1);
                        state_q <= S_RD_I;
                    end
                end
                S_DONE: begin
                    wren_q <= 1'b0;
                    rden_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        done_q <= 1'b1;
                    end else begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign address = address_q;
    assign data    = data_q;
    assign wren    = wren_q;
    assign rden    = rden_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_ksa_fsm.sv
// tb/tb_ksa_fsm.sv - self-checking bench for ksa_fsm against an RC4 KSA reference model
module tb_ksa_fsm;
    localparam int LIMIT     = 3000;
    localparam int LAT       = 2818;
    localparam int STOP_EDGE = 258 + 10*100 + 7;  // WR_J of iteration i=100
    localparam int RST_EDGE  = 38;                // INIT cycle writing i=37

    logic        clk = 1'b0;
    logic        reset, start, stop;
    logic [23:0] secret_key;
    logic [7:0]  q, address, data;
    logic        wren, rden, busy, done;

    always #5 clk = ~clk;

    ksa_fsm dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .secret_key(secret_key), .q(q), .address(address), .data(data),
        .wren(wren), .rden(rden), .busy(busy), .done(done)
    );

    // RAM with two-cycle read latency: registered address stage, registered output.
    logic [7:0] mem [256];
    logic [7:0] q1;
    always @(posedge clk) begin
        q1 <= mem[address];
        q  <= q1;
        if (wren) mem[address] <= data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t trace[$];
    wr_t exp_wr[$];
    wr_t mon_w;
    always @(negedge clk) begin
        if (wren) begin
            mon_w.cyc = cyc;
            mon_w.a   = address;
            mon_w.d   = data;
            trace.push_back(mon_w);
        end
    end

    int pass_cnt = 0;
    int total    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: textbook RC4 key schedule plus the write sequence it implies.
    logic [7:0] ms [256];
    task automatic run_model(input logic [23:0] key, input int iters);
        logic [7:0] kb [3];
        logic [7:0] t;
        int j;
        wr_t w;
        kb[0] = key[23:16];
        kb[1] = key[15:8];
        kb[2] = key[7:0];
        exp_wr.delete();
        w.cyc = 0;
        for (int i = 0; i < 256; i++) begin
            ms[i] = 8'(i);
            w.a = 8'(i);
            w.d = 8'(i);
            exp_wr.push_back(w);
        end
        j = 0;
        for (int i = 0; i < iters; i++) begin
            j = (j + int'(ms[i]) + int'(kb[i % 3])) % 256;
            w.a = 8'(j); w.d = ms[i]; exp_wr.push_back(w);
            w.a = 8'(i); w.d = ms[j]; exp_wr.push_back(w);
            t = ms[i]; ms[i] = ms[j]; ms[j] = t;
        end
    endtask

    task automatic compare_ram(input string tag);
        int bad;
        bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== ms[k]) bad++;
        check({tag, "_ram_mismatches"}, bad, 0);
        check({tag, "_s0"}, mem[0], ms[0]);
        check({tag, "_s255"}, mem[255], ms[255]);
    endtask

    task automatic compare_trace(input string tag, input int base);
        int bad, n;
        check({tag, "_wr_count"}, trace.size(), exp_wr.size());
        n = (trace.size() < exp_wr.size()) ? trace.size() : exp_wr.size();
        bad = 0;
        for (int k = 0; k < n; k++)
            if (trace[k].a !== exp_wr[k].a || trace[k].d !== exp_wr[k].d) bad++;
        check({tag, "_wr_seq"}, bad, 0);
        bad = 0;
        for (int k = 0; k < 256 && k < trace.size(); k++)
            if (trace[k].cyc != base + 1 + k) bad++;
        check({tag, "_init_consecutive"}, bad, 0);
        check({tag, "_first_ksa_wr_cycle"}, (trace.size() > 256) ? trace[256].cyc - base : -1, 265);
    endtask

    // kind: 0 full run, 1 stop at abort_edge, 2 reset at abort_edge. start held as a level.
    task automatic do_run(input logic [23:0] key, input int kind, input int abort_edge,
                          output int lat, output int base);
        for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
        trace.delete();
        @(negedge clk);
        secret_key = key;
        start = 1'b1;
        @(posedge clk);
        #1;
        base = cyc;
        lat = -1;
        for (int n = 1; n <= LIMIT; n++) begin
            @(negedge clk);
            if (n == abort_edge) begin
                start = 1'b0;
                if (kind == 1) stop = 1'b1;
                else reset = 1'b1;
            end
            @(posedge clk);
            #1;
            stop = 1'b0;
            reset = 1'b0;
            if (n == 1000) check("busy_mid_run", busy, 1);
            if (n == abort_edge) break;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic finish_full(input string tag, input logic [23:0] key, input int base);
        check({tag, "_busy_at_done"}, busy, 0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, done, 0);
        run_model(key, 256);
        compare_trace(tag, base);
        compare_ram(tag);
    endtask

    typedef struct {
        logic [23:0] key;
        int          kind;
        int          abort_edge;
        int          exp_lat;
        int          exp_iters;
    } vec_t;
    vec_t vec [6];

    initial begin
        int lat, base, sz, bad;
        logic [23:0] key;
        vec[0] = '{24'h000000, 0, -1, LAT, 256};
        vec[1] = '{24'h000249, 0, -1, LAT, 256};
        vec[2] = '{24'($urandom), 1, STOP_EDGE, -1, 100};
        vec[3] = '{24'($urandom), 0, -1, LAT, 256};
        vec[4] = '{24'($urandom), 2, RST_EDGE, -1, 0};
        vec[5] = '{24'($urandom), 0, -1, LAT, 256};

        reset = 1'b1; start = 1'b0; stop = 1'b0; secret_key = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_address", address, 0);
        check("rst_data", data, 0);
        check("rst_wren", wren, 0);
        check("rst_rden", rden, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int t = 0; t < 6; t++) begin
            do_run(vec[t].key, vec[t].kind, vec[t].abort_edge, lat, base);
            check($sformatf("v%0d_latency", t), lat, vec[t].exp_lat);
            if (vec[t].kind == 0) begin
                finish_full($sformatf("v%0d", t), vec[t].key, base);
            end else if (vec[t].kind == 1) begin
                check("stop_wren", wren, 0);
                check("stop_busy", busy, 0);
                check("stop_done", done, 0);
                repeat (3) @(posedge clk);
                #1;
                check("stop_stays_idle", busy, 0);
                run_model(vec[t].key, vec[t].exp_iters);
                compare_trace("stop", base);
                compare_ram("stop");
            end else begin
                check("midrst_address", address, 0);
                check("midrst_data", data, 0);
                check("midrst_wren", wren, 0);
                check("midrst_rden", rden, 0);
                check("midrst_busy", busy, 0);
                check("midrst_done", done, 0);
            end
        end

        // Hold start after done: DONE must persist, ignore stop, and issue no writes.
        key = 24'($urandom);
        do_run(key, 0, -1, lat, base);
        check("hold_latency", lat, LAT);
        sz = trace.size();
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            stop = (k == 20);
            @(posedge clk);
            #1;
            stop = 1'b0;
            if (done !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("hold_done_stable", bad, 0);
        check("hold_no_writes", trace.size(), sz);
        finish_full("hold", key, base);

        key = 24'($urandom);
        do_run(key, 0, -1, lat, base);
        check("rerun_latency", lat, LAT);
        finish_full("rerun", key, base);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/ksa_fsm.md
Name: ksa_fsm

Overview:
- Builds the RC4 state array S in the shared 256x8 working RAM, in two phases: an init phase (s[i]=i) followed by key scheduling with the 24-bit secret key.
- Sits directly upstream of the decrypt FSM.
- Its done output drives the decrypt FSM's start.
- One instance per cracking core; stop aborts the core when another core has found the key.

Parameters:
- KEY_BYTES, 3, key length in bytes; key byte index is i mod KEY_BYTES.
- MEM_LAT, 2, RAM read latency in cycles (wait states between address and q sample).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin init+KSA (level, sampled in IDLE)
- stop  input  1  abort request from the core arbiter
- secret_key  input  24  key; key[0]=[23:16], key[1]=[15:8], key[2]=[7:0]
- q  input  8  RAM read data
- address  output  8  RAM address
- data  output  8  RAM write data
- wren  output  1  RAM write enable
- rden  output  1  RAM read enable
- busy  output  1  high in any state other than IDLE and DONE
- done  output  1  S array ready; high only in DONE

Behaviour:
- All outputs are registered.
- Reset (sync, active-high): state=IDLE; address=0, data=0, wren=0, rden=0, busy=0, done=0; i=0, j=0.
  - Reset wins over every other input, including mid-operation.
- RAM timing: address, data and wren are presented together.
  - A write commits at the next edge.
  - q is valid for sampling MEM_LAT cycles after the address update.
- IDLE: start=1 → INIT with i=0. Otherwise stay.
- INIT (256 cycles): each cycle address<=i, data<=i, wren<=1, i<=i+1. After writing i=255 → INIT_END.
- INIT_END: wren<=0, rden<=1, i<=0, j<=0 → RD_I.
- KSA loop, 10 cycles per iteration:
  - RD_I: address<=i.
  - W_I1, W_I2: wait.
  - CALC_J: tmp_i<=q; j<=(j+q+key[i mod 3]) mod 256.
  - RD_J: address<=j.
  - W_J1, W_J2: wait.
  - WR_J: tmp_j<=q; wren<=1; rden<=0; data<=tmp_i (address still j).
  - WR_I: address<=i; data<=tmp_j; wren stays 1.
  - NEXT: wren<=0; rden<=1. If i==255 → DONE; else i<=i+1 → RD_I.
- Arithmetic is 8-bit, wrapping mod 256. The i mod 3 index is a 2-bit counter reset with i and wrapping 2→0.
- i==j: both writes carry the same value (s[j] was read before either write), so S is unchanged. No special case is needed.
- DONE: done=1, busy=0, wren=0. Stay while start=1; start=0 → IDLE with done<=0. DONE does not restart while start is held.
- Latency: done rises exactly 2818 edges after the edge that sampled start in IDLE (1 + 256 + 1 + 2560).
- stop=1 in any state except IDLE/DONE → IDLE at the next edge.
  - wren<=0, rden<=0, done stays 0.
  - stop overrides that state's normal action, so no write is issued in that cycle.
- stop in IDLE or DONE is ignored.
- secret_key must be stable while busy; it is sampled every CALC_J.
- start asserted while busy is ignored.

Test Plan:
- secret_key=24'h000000 → done at edge 2818. RAM dump equals the software RC4 KSA for key {00,00,00}; spot-check s[0] and s[255] against the model.
- secret_key=24'h000249 → full 256-byte dump matches the reference model. wren is never high in RD_I/W_*/CALC_J/RD_J.
- During INIT → exactly 256 consecutive write cycles with address=data=0..255, then wren low.
- stop pulsed in KSA iteration i=100 (in WR_J) → that write suppressed, wren=0 at the next edge, state IDLE, done stays 0. Then start → a full run completes correctly.
- reset asserted mid-INIT (i=37) → all outputs at reset values at the next edge. Re-start gives a correct result.
- start held high after done → remains in DONE with no RAM writes. Drop start → done=0 next edge. Raise start → new run, done at +2818.
